paralelo_serial_tx: RTL and testbench

PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

---
 rtl/paralelo_serial_pkg.sv | 14 +
 rtl/paralelo_serial_tx.sv | 84 ++++++++
 tb/tb_paralelo_serial_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_pkg.sv
// Shared constants and state encoding for the paralelo_serial link.
// Imported by both the TX serializer and the RX deserializer.
package paralelo_serial_pkg;

    localparam logic [7:0] COM_CHAR = 8'hBC;
    localparam int SYNC_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } link_state_t;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: MSB-first, back-to-back 8-bit slots.
// Sends a comma preamble after reset, then data or idle commas per slot.
import paralelo_serial_pkg::*;

module paralelo_serial_tx #(
    parameter logic [7:0] COM = COM_CHAR,
    parameter int SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out
);

    localparam int SW = $clog2(SYNC_COUNT + 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_COUNT);

    link_state_t state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [SW-1:0] sync_cnt;
    logic boundary;
    logic [7:0] slot_byte;

    assign boundary  = (bit_cnt == 3'd7);
    assign slot_byte = valid_in ? data_in : COM;
    assign data_out  = shreg[7];

    // ready only when the upcoming boundary will actually accept data
    assign ready_out = boundary &&
        ((state == ST_ACTIVE) ||
         ((state == ST_SYNC) && (sync_cnt == SYNC_LAST)));

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            sync_cnt   <= '0;
            active_out <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    shreg    <= COM;
                    bit_cnt  <= 3'd0;
                    sync_cnt <= SW'(1);
                    state    <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (boundary) begin
                        bit_cnt <= 3'd0;
                        if (sync_cnt == SYNC_LAST) begin
                            state      <= ST_ACTIVE;
                            active_out <= 1'b1;
                            shreg      <= slot_byte;
                        end else begin
                            shreg    <= COM;
                            sync_cnt <= sync_cnt + SW'(1);
                        end
                    end else begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (boundary) begin
                        bit_cnt <= 3'd0;
                        shreg   <= slot_byte;
                    end else begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx against a slot-level link model.
// Directed scenarios followed by randomized valid/data and resets.
module tb_paralelo_serial_tx;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int NSYNC = 4;

    logic clk_32f = 1'b0;
    logic reset;
    logic [7:0] data_in;
    logic valid_in;
    logic ready_out;
    logic data_out;
    logic active_out;

    typedef struct {
        logic d;
        logic r;
        logic a;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit done = 1'b0;

    paralelo_serial_tx dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .active_out (active_out)
    );

    always #5 clk_32f = ~clk_32f;

    // Reference model: edge n after release falls in slot (n-1)/8 at bit
    // (n-1)%8; the first NSYNC slots are commas, later slots take the
    // byte offered on their first edge (or a comma when none is offered).
    initial begin
        int n;
        int pos;
        int slot;
        logic [7:0] cur;
        exp_t e;
        n = 0;
        cur = 8'h00;
        forever begin
            @(posedge clk_32f);
            cyc++;
            if (reset) begin
                n = 0;
                cur = 8'h00;
                e.d = 1'b0;
                e.r = 1'b0;
                e.a = 1'b0;
            end else begin
                n++;
                pos = (n - 1) % 8;
                slot = (n - 1) / 8;
                if (pos == 0)
                    cur = (slot >= NSYNC && valid_in) ? data_in : COMMA;
                e.d = cur[7 - pos];
                e.r = (pos == 7) && (slot >= NSYNC - 1);
                e.a = (slot >= NSYNC);
            end
            sb.push_back(e);
        end
    end

    // Monitor: one expected triple per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_32f);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks += 3;
                if (data_out !== e.d) begin
                    errors++;
                    $display("FAIL data_out cyc %0d got %b exp %b",
                             cyc, data_out, e.d);
                end
                if (ready_out !== e.r) begin
                    errors++;
                    $display("FAIL ready_out cyc %0d got %b exp %b",
                             cyc, ready_out, e.r);
                end
                if (active_out !== e.a) begin
                    errors++;
                    $display("FAIL active_out cyc %0d got %b exp %b",
                             cyc, active_out, e.a);
                end
            end
        end
    end

    // Offer a byte and hold it until the link takes it.
    task automatic send(input logic [7:0] b);
        int t;
        valid_in = 1'b1;
        data_in = b;
        t = 0;
        while (!ready_out && t < 100) begin
            @(negedge clk_32f);
            t++;
        end
        if (t >= 100) begin
            errors++;
            $display("FAIL send_timeout byte %h got ready 0 exp 1", b);
        end
        @(negedge clk_32f);
        valid_in = 1'b0;
    endtask

    task automatic do_reset(input int edges);
        reset = 1'b1;
        valid_in = 1'b0;
        repeat (edges) @(negedge clk_32f);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        valid_in = 1'b0;
        data_in = 8'h00;
        do_reset(3);

        // Comma preamble with nothing to send, then single bytes.
        repeat (40) @(negedge clk_32f);
        send(8'hA5);
        repeat (12) @(negedge clk_32f);
        send(8'h01);
        send(8'hFF);
        send(8'h80);
        send(COMMA);
        repeat (10) @(negedge clk_32f);

        // Byte held valid through the whole sync phase.
        do_reset(2);
        send(8'h3C);
        repeat (5) @(negedge clk_32f);

        // Abort mid-byte, then a fresh preamble before the next accept.
        send(8'hF0);
        repeat (3) @(negedge clk_32f);
        do_reset(1);
        send(8'h7E);
        send(COMMA);
        send(8'h55);
        repeat (10) @(negedge clk_32f);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset($urandom_range(1, 4));
            end else begin
                valid_in = $urandom_range(0, 1) == 1;
                data_in = ($urandom_range(0, 7) == 0) ?
                          COMMA : 8'($urandom);
                @(negedge clk_32f);
            end
        end
        valid_in = 1'b0;
        repeat (4) @(negedge clk_32f);
        done = 1'b1;
    end

    initial begin
        int t;
        t = 0;
        while (!done && t < 20000) begin
            @(negedge clk_32f);
            t++;
        end
        if (!done) begin
            errors++;
            $display("FAIL watchdog got done 0 exp 1");
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
